cs_word_pipe: RTL
=================

// Module: cs_word_pipe
// PURPOSE
//  Parametrised control-word pipeline that sits between the microcode ROM and the
//  control-signal field mapper. Delays the packed control word by DEPTH stages.
//  Supports stall (hold) and flush (inject the idle NOP word).
//  Sanitises illegal data-bus strobe combinations and flags them with a sticky error.
// PARAMETERS
//  CS_WIDTH   59          width of packed control word
//  DEPTH      2           pipeline stages, >=1 (latency in unstalled cycles)
//  NREAD_BIT  30          bit index of active-low db_nread strobe
//  NWRITE_BIT 2           bit index of active-low db_nwrite strobe
//  NOP_WORD   59'h40000004 idle word; both bus strobes high, all writes low
// PORTS
//  clk           in   1         system clock, rising edge
//  rst           in   1         asynchronous reset, active-high
//  cs_in         in   CS_WIDTH  control word from microcode ROM
//  cs_in_valid   in   1         cs_in carries a real word this cycle
//  stall         in   1         hold all stages
//  flush         in   1         discard all in-flight words
//  cs_in_ready   out  1         = !stall; word accepted when valid&&ready&&!flush
//  cs_out        out  CS_WIDTH  last-stage word; NOP_WORD when last stage invalid
//  cs_out_valid  out  1         last stage holds a real word
//  bus_conflict  out  1         sticky: an accepted word had both strobes low
// BEHAVIOUR
//  - Reset (async, rst=1): every stage word=NOP_WORD, valid=0; bus_conflict=0.
//    Outputs are cs_out=NOP_WORD and cs_out_valid=0 immediately, without waiting for clk.
//  - Storage: DEPTH stages, each holding {word, valid}. Stage 0 is fed by the input.
//    Stage DEPTH-1 drives the outputs.
//  - Priority per rising edge: flush > stall > advance.
//  - flush=1: all stages word=NOP_WORD, valid=0; cs_in is dropped, even if valid.
//    cs_out=NOP_WORD from the next cycle.
//  - stall=1 (no flush): all stages hold; cs_in is not accepted; cs_out is held stable.
//  - advance: stage[i] <= stage[i-1] for i>=1.
//    stage[0] <= {sanitised cs_in, 1} if cs_in_valid, else {NOP_WORD, 0}.
//  - Latency: a word accepted at edge n appears on cs_out after edge n+DEPTH-1.
//    Each stalled edge adds one cycle. Throughput is 1 word/cycle when not stalled.
//  - cs_out is combinational from the last stage: valid ? word : NOP_WORD.
//    An invalid stage never leaks stale bits.
//  - Sanitise: an accepted word with bit NREAD_BIT=0 and bit NWRITE_BIT=0 is stored
//    with both bits forced to 1. All other bits pass unchanged.
//    On the same edge bus_conflict<=1; it clears only on rst.
//  - A conflicting word that is dropped by stall or flush does not set bus_conflict.
//  - flush and stall together: the flush takes effect and the pipeline empties.
//  - Reset asserted mid-operation: all in-flight words are lost; no partial state remains.
// CONFIGURATION
//  CS_STALL_CNT_EN defined: adds output stall_cnt [15:0].
//   - Reset to 0. Increments on each edge where stall=1 and flush=0.
//   - Saturates at 16'hFFFF. Does not clear on flush.
//  CS_STALL_CNT_EN undefined: port and counter are absent; behaviour is otherwise identical.
// TESTING
//  1 rst=1 then release -> cs_out=59'h40000004, cs_out_valid=0, bus_conflict=0.
//  2 DEPTH=2: words A=0x1,B=0x2,C=0x3 valid on edges 1-3, no stall
//    -> cs_out=A after edge 2, B after 3, C after 4; cs_out_valid high on those 3 cycles.
//  3 A accepted, stall=1 for edges 2-4 -> cs_out/valid frozen; cs_in_ready=0;
//    A on cs_out after edge 5. With CS_STALL_CNT_EN, stall_cnt=3.
//  4 Two words in flight, flush=1 with stall=1 -> next cycle cs_out=NOP_WORD, valid=0.
//    Words presented during the flush never appear.
//  5 cs_in=0 (both strobes low), valid, no stall -> emerges as 0x40000004;
//    bus_conflict=1 after the accept edge and stays 1 through flush until rst.
//  6 Same illegal word presented only while stall=1 -> bus_conflict stays 0.
//    Then rst pulse mid-stream -> cs_out=NOP_WORD asynchronously.

Source files
------------

// File: rtl/cs_word_pipe.sv
// Control-word delay pipeline with stall/flush and bus-strobe sanitising.
// Optional stall counter output enabled by defining CS_STALL_CNT_EN.
module cs_word_pipe #(
    parameter int                     CS_WIDTH   = 59,
    parameter int                     DEPTH      = 2,
    parameter int                     NREAD_BIT  = 30,
    parameter int                     NWRITE_BIT = 2,
    parameter logic [CS_WIDTH-1:0]    NOP_WORD   = 59'h40000004
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CS_WIDTH-1:0] cs_in,
    input  logic                cs_in_valid,
    input  logic                stall,
    input  logic                flush,
    output logic                cs_in_ready,
    output logic [CS_WIDTH-1:0] cs_out,
    output logic                cs_out_valid,
`ifdef CS_STALL_CNT_EN
    output logic [15:0]         stall_cnt,
`endif
    output logic                bus_conflict
);

    // Both active-low strobes asserted at once would drive the data bus both ways.
    function automatic logic f_strobe_conflict(input logic [CS_WIDTH-1:0] w);
        return (w[NREAD_BIT] == 1'b0) && (w[NWRITE_BIT] == 1'b0);
    endfunction

    function automatic logic [CS_WIDTH-1:0] f_sanitise(input logic [CS_WIDTH-1:0] w);
        logic [CS_WIDTH-1:0] v;
        v = w;
        if (f_strobe_conflict(w)) begin
            v[NREAD_BIT]  = 1'b1;
            v[NWRITE_BIT] = 1'b1;
        end else begin
            v = w;
        end
        return v;
    endfunction

    logic [CS_WIDTH-1:0] r_word [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic                r_bus_conflict;
    logic                w_accept;
    logic                w_conflict;

    // Acceptance and conflict detection for the word presented this cycle.
    always_comb begin
        w_accept   = cs_in_valid && !stall && !flush;
        w_conflict = w_accept && f_strobe_conflict(cs_in);
    end

    // Stage storage: flush beats stall beats advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_word[i] <= NOP_WORD;
            end
            r_valid <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_word[i] <= NOP_WORD;
            end
            r_valid <= '0;
        end else if (!stall) begin
            for (int i = 1; i < DEPTH; i++) begin
                r_word[i]  <= r_word[i-1];
                r_valid[i] <= r_valid[i-1];
            end
            if (cs_in_valid) begin
                r_word[0]  <= f_sanitise(cs_in);
                r_valid[0] <= 1'b1;
            end else begin
                r_word[0]  <= NOP_WORD;
                r_valid[0] <= 1'b0;
            end
        end
    end

    // Sticky conflict flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_conflict <= 1'b0;
        end else if (w_conflict) begin
            r_bus_conflict <= 1'b1;
        end
    end

`ifdef CS_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of edges spent stalled (flush edges excluded).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'h0000;
        end else if (stall && !flush && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    // Output mux: an invalid last stage always presents the idle word.
    always_comb begin
        cs_in_ready  = !stall;
        cs_out_valid = r_valid[DEPTH-1];
        if (r_valid[DEPTH-1]) begin
            cs_out = r_word[DEPTH-1];
        end else begin
            cs_out = NOP_WORD;
        end
    end

    assign bus_conflict = r_bus_conflict;

endmodule
